i2c_wb_arbiter: RTL and testbench



---
 rtl/i2c_wb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_i2c_wb_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the I2C core register port; a grant spans a whole I2C transaction.
// Optional stall timeout is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req,
    input  logic       m1_req,
    output logic       m0_gnt,
    output logic       m1_gnt,
    input  logic [2:0] m0_addr,
    input  logic [2:0] m1_addr,
    input  logic [7:0] m0_wr_data,
    input  logic [7:0] m1_wr_data,
    input  logic       m0_we,
    input  logic       m0_stb,
    input  logic       m0_cyc,
    input  logic       m1_we,
    input  logic       m1_stb,
    input  logic       m1_cyc,
    output logic [7:0] m0_rd_data,
    output logic [7:0] m1_rd_data,
    output logic       m0_ack,
    output logic       m1_ack,
    output logic       m0_err,
    output logic       m1_err,
    output logic [2:0] s_addr,
    output logic [7:0] s_wr_data,
    output logic       s_we,
    output logic       s_stb,
    output logic       s_cyc,
    input  logic [7:0] s_rd_data,
    input  logic       s_ack,
    output logic       owner
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, FLUSH} state_t;

    state_t state;
    state_t arb_state;
    logic   arb_owner;
    logic   req0_ok;
    logic   req1_ok;
    logic   rel0;
    logic   rel1;
    logic   timeout;

    // A master with a cycle still open keeps the grant until the core acks it.
    assign rel0 = !m0_req && (!m0_cyc || s_ack);
    assign rel1 = !m1_req && (!m1_cyc || s_ack);

    always_comb begin
        arb_state = IDLE;
        arb_owner = owner;
        if (req0_ok && req1_ok) begin
            arb_state = owner ? GNT0 : GNT1;
            arb_owner = !owner;
        end else if (req0_ok) begin
            arb_state = GNT0;
            arb_owner = 1'b0;
        end else if (req1_ok) begin
            arb_state = GNT1;
            arb_owner = 1'b1;
        end
    end

    always_comb begin
        s_addr    = '0;
        s_wr_data = '0;
        s_we      = 1'b0;
        s_stb     = 1'b0;
        s_cyc     = 1'b0;
        case (state)
            GNT0: begin
                s_addr    = m0_addr;
                s_wr_data = m0_wr_data;
                s_we      = m0_we;
                s_stb     = m0_stb;
                s_cyc     = m0_cyc;
            end
            GNT1: begin
                s_addr    = m1_addr;
                s_wr_data = m1_wr_data;
                s_we      = m1_we;
                s_stb     = m1_stb;
                s_cyc     = m1_cyc;
            end
            default: ;
        endcase
    end

    // Read data is gated to the owner so register contents never leak across requesters.
    assign m0_ack     = (state == GNT0) && s_ack;
    assign m1_ack     = (state == GNT1) && s_ack;
    assign m0_rd_data = m0_ack ? s_rd_data : 8'h00;
    assign m1_rd_data = m1_ack ? s_rd_data : 8'h00;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] stall_cnt;
    logic       blk0;
    logic       blk1;
    logic       in_gnt;
    logic       stalling;

    assign in_gnt   = (state == GNT0) || (state == GNT1);
    assign stalling = in_gnt && s_cyc && s_stb && !s_ack;
    assign timeout  = stalling && (stall_cnt == STALL_LAST);
    assign req0_ok  = m0_req && !blk0;
    assign req1_ok  = m1_req && !blk1;

    // A timed-out master stays blocked until it has dropped req for a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            blk0      <= 1'b0;
            blk1      <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
        end else begin
            m0_err <= timeout && (state == GNT0);
            m1_err <= timeout && (state == GNT1);
            if (timeout || s_ack || !in_gnt) begin
                stall_cnt <= '0;
            end else if (stalling) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
            if (!m0_req) begin
                blk0 <= 1'b0;
            end else if (timeout && (state == GNT0)) begin
                blk0 <= 1'b1;
            end
            if (!m1_req) begin
                blk1 <= 1'b0;
            end else if (timeout && (state == GNT1)) begin
                blk1 <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign req0_ok = m0_req;
    assign req1_ok = m1_req;
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= 1'b1;
            m0_gnt <= 1'b0;
            m1_gnt <= 1'b0;
        end else begin
            case (state)
                IDLE, FLUSH: begin
                    state  <= arb_state;
                    m0_gnt <= (arb_state == GNT0);
                    m1_gnt <= (arb_state == GNT1);
                    if (arb_state != IDLE) begin
                        owner <= arb_owner;
                    end
                end
                GNT0: begin
                    if (rel0 || timeout) begin
                        state  <= FLUSH;
                        m0_gnt <= 1'b0;
                    end
                end
                GNT1: begin
                    if (rel1 || timeout) begin
                        state  <= FLUSH;
                        m1_gnt <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    m0_gnt <= 1'b0;
                    m1_gnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Scoreboard bench for i2c_wb_arbiter: scenarios push expected grant/ack/err events, a monitor pops and compares.
module tb_i2c_wb_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_req, m1_req, m0_gnt, m1_gnt;
    logic [2:0] m0_addr, m1_addr;
    logic [7:0] m0_wr_data, m1_wr_data;
    logic       m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
    logic [7:0] m0_rd_data, m1_rd_data;
    logic       m0_ack, m1_ack, m0_err, m1_err;
    logic [2:0] s_addr;
    logic [7:0] s_wr_data;
    logic       s_we, s_stb, s_cyc;
    logic [7:0] s_rd_data;
    logic       s_ack;
    logic       owner;

    int checks_total  = 0;
    int checks_passed = 0;
    int ack_delay     = 1;

    typedef struct {
        string      name;
        logic [1:0] gnt;
        logic [1:0] ack;
        logic [1:0] err;
        logic       own;
        logic [7:0] rd0;
        logic [7:0] rd1;
        logic       chk_bus;
        logic [2:0] addr;
        logic [7:0] wdat;
        logic       we;
    } exp_t;

    exp_t sb[$];

    i2c_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
        .m0_we(m0_we), .m0_stb(m0_stb), .m0_cyc(m0_cyc),
        .m1_we(m1_we), .m1_stb(m1_stb), .m1_cyc(m1_cyc),
        .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_err(m0_err), .m1_err(m1_err),
        .s_addr(s_addr), .s_wr_data(s_wr_data), .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
        .s_rd_data(s_rd_data), .s_ack(s_ack), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic expect_gnt(input string name, input logic [1:0] g, input logic own);
        exp_t e;
        e.name = name; e.gnt = g; e.ack = 2'b00; e.err = 2'b00; e.own = own;
        e.rd0 = 8'h00; e.rd1 = 8'h00; e.chk_bus = 1'b0; e.addr = 3'd0; e.wdat = 8'h00; e.we = 1'b0;
        sb.push_back(e);
    endtask

    task automatic expect_ack(input string name, input int m, input logic [7:0] rd,
                              input logic [2:0] addr, input logic [7:0] wdat, input logic we, input logic own);
        exp_t e;
        e.name = name; e.gnt = (m == 1) ? 2'b10 : 2'b01; e.ack = e.gnt; e.err = 2'b00; e.own = own;
        e.rd0 = (m == 0) ? rd : 8'h00; e.rd1 = (m == 1) ? rd : 8'h00;
        e.chk_bus = 1'b1; e.addr = addr; e.wdat = wdat; e.we = we;
        sb.push_back(e);
    endtask

    task automatic expect_err(input string name, input int m, input logic own);
        exp_t e;
        e.name = name; e.gnt = 2'b00; e.ack = 2'b00; e.err = (m == 1) ? 2'b10 : 2'b01; e.own = own;
        e.rd0 = 8'h00; e.rd1 = 8'h00; e.chk_bus = 1'b0; e.addr = 3'd0; e.wdat = 8'h00; e.we = 1'b0;
        sb.push_back(e);
    endtask

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [2:0] addr, input logic [7:0] data);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_addr = addr; m0_wr_data = data;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_addr = addr; m1_wr_data = data;
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic r1);
        m0_req = r0;
        m1_req = r1;
    endtask

    // One Wishbone access by the current owner; optionally drops req while the cycle is open.
    task automatic bus_access(input int m, input logic [2:0] addr, input logic [7:0] data,
                              input logic we, input logic drop_req, input string tag);
        logic got;
        got = 1'b0;
        set_bus(m, 1'b1, 1'b1, we, addr, data);
        if (drop_req) begin
            if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            checkOutput({tag, "_gnt_held"}, (m == 1) ? m1_gnt : m0_gnt, 1);
            checkOutput({tag, "_other_ack"}, (m == 1) ? m0_ack : m1_ack, 0);
            checkOutput({tag, "_other_rd"}, (m == 1) ? m0_rd_data : m1_rd_data, 0);
            checkOutput({tag, "_s_addr"}, s_addr, addr);
            checkOutput({tag, "_s_we"}, s_we, we);
            checkOutput({tag, "_s_wdat"}, s_wr_data, data);
            checkOutput({tag, "_err"}, {m1_err, m0_err}, 0);
            got = (m == 1) ? m1_ack : m0_ack;
        end
        checkOutput({tag, "_ack_seen"}, got, 1);
        next_cycle(1);
        set_bus(m, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic do_reset(input string tag);
        applyStimulus(1'b0, 1'b0);
        set_bus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        set_bus(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_gnt"}, {m1_gnt, m0_gnt}, 0);
        checkOutput({tag, "_ack"}, {m1_ack, m0_ack}, 0);
        checkOutput({tag, "_err"}, {m1_err, m0_err}, 0);
        checkOutput({tag, "_rd"}, {m1_rd_data, m0_rd_data}, 0);
        checkOutput({tag, "_s_ctl"}, {s_cyc, s_stb, s_we}, 0);
        checkOutput({tag, "_s_data"}, {s_addr, s_wr_data}, 0);
        checkOutput({tag, "_owner"}, owner, 1);
        next_cycle(1);
        rst_n = 1'b1;
    endtask

    // Core model: acks ack_delay cycles after a strobe; ack_delay 0 never acks.
    initial begin
        int cnt;
        cnt = 0;
        s_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (s_cyc && s_stb && ack_delay > 0) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    next_cycle(1);
                    s_ack = 1'b1;
                    next_cycle(1);
                    s_ack = 1'b0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        logic [1:0] prev_g;
        logic [1:0] g;
        exp_t       e;
        prev_g = 2'b00;
        forever begin
            @(negedge clk);
            g = {m1_gnt, m0_gnt};
            if (g != prev_g || m0_ack || m1_ack || m0_err || m1_err) begin
                checkOutput("sb_pending", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_gnt"}, g, e.gnt);
                    checkOutput({e.name, "_ack"}, {m1_ack, m0_ack}, e.ack);
                    checkOutput({e.name, "_err"}, {m1_err, m0_err}, e.err);
                    checkOutput({e.name, "_owner"}, owner, e.own);
                    checkOutput({e.name, "_rd0"}, m0_rd_data, e.rd0);
                    checkOutput({e.name, "_rd1"}, m1_rd_data, e.rd1);
                    if (e.chk_bus) begin
                        checkOutput({e.name, "_s_addr"}, s_addr, e.addr);
                        checkOutput({e.name, "_s_wdat"}, s_wr_data, e.wdat);
                        checkOutput({e.name, "_s_we"}, s_we, e.we);
                    end
                end
            end
            prev_g = g;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d/%0d", checks_passed, checks_total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        s_rd_data = 8'h00;
        #1;
        do_reset("reset0");

        // Single requester write.
        s_rd_data = 8'h00;
        ack_delay = 2;
        expect_gnt("s1_grant", 2'b01, 1'b0);
        expect_ack("s1_write", 0, 8'h00, 3'd0, 8'hC8, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("s1_gnt_cycle0", m0_gnt, 0);
        @(negedge clk);
        checkOutput("s1_gnt_cycle1", m0_gnt, 1);
        next_cycle(1);
        bus_access(0, 3'd0, 8'hC8, 1'b1, 1'b0, "s1_acc");
        expect_gnt("s1_release", 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0);
        next_cycle(3);

        // Tie after reset goes to m0, then alternation through one FLUSH cycle.
        do_reset("reset1");
        ack_delay = 1;
        s_rd_data = 8'h5A;
        expect_gnt("s2_tie", 2'b01, 1'b0);
        expect_ack("s2_m0_read", 0, 8'h5A, 3'd1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("s2_tie_cycle0", {m1_gnt, m0_gnt}, 0);
        next_cycle(1);
        bus_access(0, 3'd1, 8'h00, 1'b0, 1'b0, "s2_m0");
        set_bus(0, 1'b0, 1'b0, 1'b1, 3'd5, 8'hAA);
        set_bus(1, 1'b0, 1'b0, 1'b1, 3'd3, 8'h11);
        expect_gnt("s2_flush", 2'b00, 1'b0);
        expect_gnt("s2_m1_grant", 2'b10, 1'b1);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("s2_release_cycle", m0_gnt, 1);
        @(negedge clk);
        checkOutput("s2_flush_ctl", {s_cyc, s_stb, s_we}, 0);
        checkOutput("s2_flush_data", {s_addr, s_wr_data}, 0);
        checkOutput("s2_flush_gnt", {m1_gnt, m0_gnt}, 0);
        @(negedge clk);
        checkOutput("s2_m1_pass", {s_addr, s_wr_data, s_we}, {3'd3, 8'h11, 1'b1});
        set_bus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        next_cycle(1);
        ack_delay = 2;
        expect_ack("s2_m1_write", 1, 8'h5A, 3'd3, 8'h11, 1'b1, 1'b1);
        bus_access(1, 3'd3, 8'h11, 1'b1, 1'b0, "s2_m1");

        // Read isolation: m0 misbehaves with stb/cyc while m1 owns the core.
        s_rd_data = 8'h82;
        set_bus(0, 1'b1, 1'b1, 1'b1, 3'd7, 8'hFF);
        expect_ack("s3_m1_read_sr", 1, 8'h82, 3'd4, 8'h00, 1'b0, 1'b1);
        bus_access(1, 3'd4, 8'h00, 1'b0, 1'b0, "s3_iso");
        set_bus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        expect_gnt("s3_m1_release", 2'b00, 1'b1);
        applyStimulus(1'b0, 1'b0);
        next_cycle(3);
        expect_gnt("s3_tie2", 2'b01, 1'b0);
        applyStimulus(1'b1, 1'b1);
        next_cycle(2);

        // Late release: m0 drops req with its cycle still open.
        ack_delay = 3;
        s_rd_data = 8'h3C;
        expect_ack("s4_late_ack", 0, 8'h3C, 3'd2, 8'h99, 1'b1, 1'b0);
        expect_gnt("s4_flush", 2'b00, 1'b0);
        expect_gnt("s4_m1_grant", 2'b10, 1'b1);
        bus_access(0, 3'd2, 8'h99, 1'b1, 1'b1, "s4_late");
        @(negedge clk);
        checkOutput("s4_flush_cyc", {s_cyc, m1_gnt, m0_gnt}, 0);
        @(negedge clk);
        checkOutput("s4_m1_gnt", m1_gnt, 1);
        expect_gnt("s4_m1_release", 2'b00, 1'b1);
        applyStimulus(1'b0, 1'b0);
        next_cycle(3);

`ifdef I2C_ARB_TIMEOUT_EN
        // Stalled access times out after TO cycles; m0 blocked until req toggles.
        ack_delay = 0;
        expect_gnt("s5_grant", 2'b01, 1'b0);
        expect_err("s5_timeout", 0, 1'b0);
        expect_gnt("s5_m1_grant", 2'b10, 1'b1);
        applyStimulus(1'b1, 1'b1);
        next_cycle(2);
        set_bus(0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h00);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            checkOutput("s5_err_early", m0_err, 0);
        end
        @(negedge clk);
        checkOutput("s5_err_pulse", m0_err, 1);
        checkOutput("s5_err_gnt", m0_gnt, 0);
        next_cycle(1);
        set_bus(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        checkOutput("s5_err_one_cycle", m0_err, 0);
        next_cycle(1);
        ack_delay = 1;
        s_rd_data = 8'h21;
        expect_ack("s5_m1_read", 1, 8'h21, 3'd6, 8'h00, 1'b0, 1'b1);
        bus_access(1, 3'd6, 8'h00, 1'b0, 1'b0, "s5_m1");
        expect_gnt("s5_m1_release", 2'b00, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) checkOutput("s5_m0_blocked", m0_gnt, 0);
        end
        next_cycle(1);
        applyStimulus(1'b0, 1'b0);
        next_cycle(1);
        expect_gnt("s5_regrant", 2'b01, 1'b0);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("s5_regrant_wait", m0_gnt, 0);
        @(negedge clk);
        checkOutput("s5_regrant_gnt", m0_gnt, 1);
        expect_gnt("s5_release", 2'b00, 1'b0);
        next_cycle(1);
        applyStimulus(1'b0, 1'b0);
        next_cycle(3);
`else
        // Without the timeout a long stall simply holds the grant.
        ack_delay = 12;
        s_rd_data = 8'h44;
        expect_gnt("s5_grant", 2'b01, 1'b0);
        expect_ack("s5_long_stall", 0, 8'h44, 3'd2, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        next_cycle(2);
        bus_access(0, 3'd2, 8'h00, 1'b0, 1'b0, "s5_stall");
        expect_gnt("s5_release", 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0);
        next_cycle(3);
`endif

        // Asynchronous reset in the middle of an access.
        ack_delay = 0;
        expect_gnt("s6_grant", 2'b10, 1'b1);
        applyStimulus(1'b0, 1'b1);
        next_cycle(2);
        set_bus(1, 1'b1, 1'b1, 1'b1, 3'd1, 8'h5C);
        @(negedge clk);
        checkOutput("s6_cyc_before", s_cyc, 1);
        expect_gnt("s6_reset_drop", 2'b00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s6_async_cyc", {s_cyc, s_stb}, 0);
        checkOutput("s6_async_gnt", {m1_gnt, m0_gnt}, 0);
        checkOutput("s6_async_owner", owner, 1);
        applyStimulus(1'b0, 1'b0);
        set_bus(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        next_cycle(1);
        rst_n = 1'b1;
        next_cycle(3);
        checkOutput("s6_idle_after", {m1_gnt, m0_gnt, owner}, 3'b001);

        checkOutput("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
